// File: rtl/pu_or1k_rf_wrarb_if.sv
// rtl/pu_or1k_rf_wrarb_if.sv - pipeline/SPR-bus/RF write-port signal bundle for the GPR write arbiter
//
// Purpose: groups the writeback request, SPR bus, ctrl advance and RF write
// port signals of pu_or1k_rf_wrarb so they travel as one port.
// master: the pipeline / SPR-bus side (drives requests, observes RF port).
// slave : the write arbiter (observes requests, drives RF port, acks, stalls).
interface pu_or1k_rf_wrarb_if #(
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
    parameter int OPTION_OPERAND_WIDTH     = 32
);
    localparam int RF_ADDR_WIDTH = OPTION_RF_ADDR_WIDTH + $clog2(OPTION_RF_NUM_SHADOW_GPR + 1);

    // writeback request
    logic                            wb_rf_wb_i;
    logic [OPTION_RF_ADDR_WIDTH-1:0] wb_rfd_adr_i;
    logic [OPTION_OPERAND_WIDTH-1:0] result_i;
    // SPR bus
    logic [15:0]                     spr_bus_addr_i;
    logic                            spr_bus_stb_i;
    logic                            spr_bus_we_i;
    logic [OPTION_OPERAND_WIDTH-1:0] spr_bus_dat_i;
    logic                            padv_ctrl_i;
    // RF write port and status
    logic                            rf_wren_o;
    logic [RF_ADDR_WIDTH-1:0]        rf_wradr_o;
    logic [OPTION_OPERAND_WIDTH-1:0] rf_wrdat_o;
    logic [RF_ADDR_WIDTH-1:0]        spr_gpr_rdadr_o;
    logic                            spr_gpr_ack_o;
    logic                            init_busy_o;
    logic                            wb_stall_o;

    modport master (
        output wb_rf_wb_i, wb_rfd_adr_i, result_i,
        output spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i, padv_ctrl_i,
        input  rf_wren_o, rf_wradr_o, rf_wrdat_o, spr_gpr_rdadr_o,
        input  spr_gpr_ack_o, init_busy_o, wb_stall_o
    );

    modport slave (
        input  wb_rf_wb_i, wb_rfd_adr_i, result_i,
        input  spr_bus_addr_i, spr_bus_stb_i, spr_bus_we_i, spr_bus_dat_i, padv_ctrl_i,
        output rf_wren_o, rf_wradr_o, rf_wrdat_o, spr_gpr_rdadr_o,
        output spr_gpr_ack_o, init_busy_o, wb_stall_o
    );
endinterface

// File: rtl/pu_or1k_rf_wrarb.sv
// rtl/pu_or1k_rf_wrarb.sv - GPR file write-port controller: reset clear, wb/SPR arbitration, SPR acks
//
// Purpose: after reset, walks every RF word (shadow sets included) writing
// zero while holding the pipeline; then shares the single RF write port
// between pipeline writeback (always preferred) and SPR-bus GPR writes,
// acks SPR GPR reads/writes, and asks writeback to stall when an SPR write
// has been blocked for SPR_STARVE_LIMIT consecutive cycles.
// Ports:
//   clk     clock
//   rst     asynchronous active-high reset
//   io_bus  slave side of pu_or1k_rf_wrarb_if (requests in; RF port, ack,
//           init_busy and wb_stall out)
module pu_or1k_rf_wrarb #(
    parameter int OPTION_RF_ADDR_WIDTH     = 5,
    parameter int OPTION_RF_NUM_SHADOW_GPR = 0,
    parameter int OPTION_OPERAND_WIDTH     = 32,
    parameter int OPTION_RF_CLEAR_ON_RESET = 1,
    parameter int SPR_STARVE_LIMIT         = 4
) (
    input logic                   clk,
    input logic                   rst,
    pu_or1k_rf_wrarb_if.slave     io_bus
);
    localparam int RF_ADDR_WIDTH = OPTION_RF_ADDR_WIDTH + $clog2(OPTION_RF_NUM_SHADOW_GPR + 1);
    localparam int RF_DEPTH      = 2 ** RF_ADDR_WIDTH;
    localparam int STARVE_W      = $clog2(SPR_STARVE_LIMIT + 1);

    localparam logic [RF_ADDR_WIDTH-1:0] LAST_ADR    = RF_ADDR_WIDTH'(RF_DEPTH - 1);
    localparam logic [STARVE_W-1:0]      STARVE_MAX  = STARVE_W'(SPR_STARVE_LIMIT);
    localparam logic                     CLEAR_EN    = (OPTION_RF_CLEAR_ON_RESET != 0);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                    r_state;
    logic [RF_ADDR_WIDTH-1:0]  r_clr_cnt;
    logic [STARVE_W-1:0]       r_starve_cnt;
    logic                      r_read_ack;

    logic                            w_spr_sel;
    logic                            w_spr_we;
    logic                            w_spr_re;
    logic [RF_ADDR_WIDTH-1:0]        w_wb_adr;
    logic [RF_ADDR_WIDTH-1:0]        w_spr_adr;
    logic                            w_wren;
    logic [RF_ADDR_WIDTH-1:0]        w_wradr;
    logic [OPTION_OPERAND_WIDTH-1:0] w_wrdat;
    logic                            w_ack;
    logic                            w_busy;
    logic                            w_stall;
    logic                            w_unused_addr_bits;

    // GPR space is SPR group 0, offset 0x400 (addr[15:9] == 2).
    assign w_spr_sel = (io_bus.spr_bus_addr_i[15:9] == 7'h2) & io_bus.spr_bus_stb_i;
    assign w_spr_we  = w_spr_sel & io_bus.spr_bus_we_i;
    // A ctrl-stage advance would change the rfspr read address under us, so it blocks reads.
    assign w_spr_re  = w_spr_sel & ~io_bus.spr_bus_we_i & ~io_bus.padv_ctrl_i;

    // Writeback always targets context 0, so the shadow-set bits are zero.
    assign w_wb_adr  = RF_ADDR_WIDTH'(io_bus.wb_rfd_adr_i);
    assign w_spr_adr = io_bus.spr_bus_addr_i[RF_ADDR_WIDTH-1:0];

    assign w_unused_addr_bits = ^io_bus.spr_bus_addr_i[8:RF_ADDR_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_clr_cnt    <= '0;
            r_starve_cnt <= '0;
            r_read_ack   <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_state      <= CLEAR_EN ? ST_CLEAR : ST_RUN;
                    r_clr_cnt    <= '0;
                    r_starve_cnt <= '0;
                    r_read_ack   <= 1'b0;
                end
                ST_CLEAR: begin
                    r_clr_cnt    <= r_clr_cnt + 1'b1;
                    r_starve_cnt <= '0;
                    r_read_ack   <= 1'b0;
                    if (r_clr_cnt == LAST_ADR)
                        r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // First qualifying read cycle presents the address to rfspr;
                    // the data is valid (and acked) on the next one.
                    r_read_ack <= w_spr_re;
                    // Count consecutive cycles where writeback beat a pending SPR write.
                    if (w_spr_we && io_bus.wb_rf_wb_i) begin
                        if (r_starve_cnt != STARVE_MAX)
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                default: begin
                    r_state      <= ST_INIT;
                    r_clr_cnt    <= '0;
                    r_starve_cnt <= '0;
                    r_read_ack   <= 1'b0;
                end
            endcase
        end
    end

    // Write port, acks and stall follow the request lines within the cycle.
    always_comb begin
        w_wren  = 1'b0;
        w_wradr = '0;
        w_wrdat = '0;
        w_ack   = 1'b0;
        w_busy  = 1'b0;
        w_stall = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_busy = CLEAR_EN;
            end
            ST_CLEAR: begin
                w_wren  = 1'b1;
                w_wradr = r_clr_cnt;
                w_busy  = 1'b1;
            end
            ST_RUN: begin
                w_wradr = w_wb_adr;
                w_wrdat = io_bus.result_i;
                if (io_bus.wb_rf_wb_i) begin
                    w_wren = 1'b1;
                end else if (w_spr_we) begin
                    w_wren  = 1'b1;
                    w_wradr = w_spr_adr;
                    w_wrdat = io_bus.spr_bus_dat_i;
                    w_ack   = 1'b1;
                end
                if (w_spr_re && r_read_ack)
                    w_ack = 1'b1;
                w_stall = (r_starve_cnt == STARVE_MAX) & w_spr_we;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    assign io_bus.rf_wren_o       = w_wren;
    assign io_bus.rf_wradr_o      = w_wradr;
    assign io_bus.rf_wrdat_o      = w_wrdat;
    assign io_bus.spr_gpr_rdadr_o = w_spr_adr;
    assign io_bus.spr_gpr_ack_o   = w_ack;
    assign io_bus.init_busy_o     = w_busy;
    assign io_bus.wb_stall_o      = w_stall;
endmodule

// File: tb/tb_pu_or1k_rf_wrarb.sv
// tb/tb_pu_or1k_rf_wrarb.sv - self-checking bench for pu_or1k_rf_wrarb
module tb_pu_or1k_rf_wrarb;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pu_or1k_rf_wrarb_if #(.OPTION_RF_NUM_SHADOW_GPR(0)) bus0 ();
    pu_or1k_rf_wrarb_if #(.OPTION_RF_NUM_SHADOW_GPR(1)) bus1 ();

    pu_or1k_rf_wrarb #(.OPTION_RF_NUM_SHADOW_GPR(0), .SPR_STARVE_LIMIT(LIMIT))
        u_dut0 (.clk(clk), .rst(rst), .io_bus(bus0));
    pu_or1k_rf_wrarb #(.OPTION_RF_NUM_SHADOW_GPR(1), .SPR_STARVE_LIMIT(LIMIT))
        u_dut1 (.clk(clk), .rst(rst), .io_bus(bus1));

    // Both instances see the same requests.
    assign bus1.wb_rf_wb_i     = bus0.wb_rf_wb_i;
    assign bus1.wb_rfd_adr_i   = bus0.wb_rfd_adr_i;
    assign bus1.result_i       = bus0.result_i;
    assign bus1.spr_bus_addr_i = bus0.spr_bus_addr_i;
    assign bus1.spr_bus_stb_i  = bus0.spr_bus_stb_i;
    assign bus1.spr_bus_we_i   = bus0.spr_bus_we_i;
    assign bus1.spr_bus_dat_i  = bus0.spr_bus_dat_i;
    assign bus1.padv_ctrl_i    = bus0.padv_ctrl_i;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        wb;
        logic [4:0]  rfd;
        logic [31:0] res;
        logic [15:0] addr;
        logic        stb;
        logic        we;
        logic [31:0] sdat;
        logic        padv;
        logic        e_wren;
        logic [4:0]  e_adr;
        logic [31:0] e_dat;
        logic        e_ack;
        logic        e_stall;
    } vec_t;

    vec_t tbl[12];

    // reference-model history
    int m_prev_re;
    int m_blocked;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [43:0] pack(input logic busy, input logic wren, input logic ack,
                                         input logic stall, input logic [7:0] adr,
                                         input logic [31:0] dat);
        return {busy, wren, ack, stall, wren ? adr : 8'h0, wren ? dat : 32'h0};
    endfunction

    function automatic logic [43:0] obs0();
        return pack(bus0.init_busy_o, bus0.rf_wren_o, bus0.spr_gpr_ack_o, bus0.wb_stall_o,
                    8'(bus0.rf_wradr_o), bus0.rf_wrdat_o);
    endfunction

    function automatic logic [43:0] obs1();
        return pack(bus1.init_busy_o, bus1.rf_wren_o, bus1.spr_gpr_ack_o, bus1.wb_stall_o,
                    8'(bus1.rf_wradr_o), bus1.rf_wrdat_o);
    endfunction

    task automatic drive(input logic wb, input logic [4:0] rfd, input logic [31:0] res,
                         input logic [15:0] addr, input logic stb, input logic we,
                         input logic [31:0] sdat, input logic padv);
        bus0.wb_rf_wb_i     = wb;
        bus0.wb_rfd_adr_i   = rfd;
        bus0.result_i       = res;
        bus0.spr_bus_addr_i = addr;
        bus0.spr_bus_stb_i  = stb;
        bus0.spr_bus_we_i   = we;
        bus0.spr_bus_dat_i  = sdat;
        bus0.padv_ctrl_i    = padv;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Called one step after reset release (INIT cycle). Clear walks the whole RF of each instance.
    task automatic clear_seq();
        for (int c = 0; c <= 65; c++) begin
            if (c <= 32)
                drive(1'($urandom), 5'($urandom), $urandom, 16'($urandom), 1'($urandom),
                      1'($urandom), $urandom, 1'($urandom));
            else
                drive(0, 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (c == 0)       chk("clr0_init", obs0(), pack(1, 0, 0, 0, 0, 0));
            else if (c <= 32) chk("clr0_walk", obs0(), pack(1, 1, 0, 0, 8'(c - 1), 0));
            else              chk("clr0_run",  obs0(), pack(0, 0, 0, 0, 0, 0));
            if (c == 0)       chk("clr1_init", obs1(), pack(1, 0, 0, 0, 0, 0));
            else if (c <= 64) chk("clr1_walk", obs1(), pack(1, 1, 0, 0, 8'(c - 1), 0));
            else              chk("clr1_run",  obs1(), pack(0, 0, 0, 0, 0, 0));
            next_cycle();
        end
    endtask

    initial begin
        logic        r_wb, r_stb, r_we, r_padv;
        logic [4:0]  r_rfd;
        logic [31:0] r_res, r_sdat;
        logic [15:0] r_addr;
        logic        sel, spr_we, spr_re, e_wren, e_ack, e_stall;
        logic [7:0]  e_adr;
        logic [31:0] e_dat;

        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 16'h0407, 1'b1, 1'b1, 32'h1234, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        16'h0407, 1'b1, 1'b1, 32'h1234, 1'b0, 1'b1, 5'd7, 32'h1234,     1'b1, 1'b0};
        tbl[2]  = '{1'b0, 5'd0, 32'h0,        16'h0000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        16'h0402, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        16'h0402, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        16'h0402, 1'b1, 1'b0, 32'h0,    1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        16'h0402, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        16'h0402, 1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0};
        tbl[8]  = '{1'b1, 5'd9, 32'hA5,       16'h0402, 1'b1, 1'b0, 32'h0,    1'b0, 1'b1, 5'd9, 32'hA5,       1'b1, 1'b0};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        16'h0802, 1'b1, 1'b1, 32'h77,   1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        16'h0407, 1'b0, 1'b1, 32'h77,   1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        16'h0000, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0};

        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_state0", obs0(), pack(1, 0, 0, 0, 0, 0));
        chk("rst_state1", obs1(), pack(1, 0, 0, 0, 0, 0));
        next_cycle();
        rst = 1'b0;
        clear_seq();

        // table-driven RUN vectors
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].wb, tbl[i].rfd, tbl[i].res, tbl[i].addr, tbl[i].stb, tbl[i].we,
                  tbl[i].sdat, tbl[i].padv);
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs0(),
                pack(0, tbl[i].e_wren, tbl[i].e_ack, tbl[i].e_stall, 8'(tbl[i].e_adr), tbl[i].e_dat));
            next_cycle();
        end

        // starvation: writeback keeps beating an SPR write to GPR 16
        for (int k = 0; k < 6; k++) begin
            drive(1, 5'd1, 32'(k), 16'h0410, 1, 1, 32'h55, 0);
            @(negedge clk);
            chk($sformatf("starve%0d", k), obs0(), pack(0, 1, 0, (k >= LIMIT), 8'd1, 32'(k)));
            next_cycle();
        end
        drive(0, 5'd1, 0, 16'h0410, 1, 1, 32'h55, 0);
        @(negedge clk);
        chk("starve_grant", obs0(), pack(0, 1, 1, 1, 8'd16, 32'h55));
        next_cycle();
        @(negedge clk);
        chk("starve_release", obs0(), pack(0, 1, 1, 0, 8'd16, 32'h55));
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        // randomized RUN traffic against the reference model
        m_prev_re = 0;
        m_blocked = 0;
        r_addr = 16'h0400; r_stb = 0; r_we = 0; r_sdat = 0;
        for (int n = 0; n < 600; n++) begin
            r_wb   = ($urandom_range(0, 99) < 75);
            r_rfd  = 5'($urandom);
            r_res  = $urandom;
            r_padv = ($urandom_range(0, 99) < 30);
            // SPR requests persist in bursts so starvation and read pairs occur
            if ($urandom_range(0, 3) == 0) begin
                r_addr = ($urandom_range(0, 9) < 8) ? {7'h2, 9'($urandom)} : 16'($urandom);
                r_stb  = ($urandom_range(0, 9) < 8);
                r_we   = 1'($urandom);
                r_sdat = $urandom;
            end
            drive(r_wb, r_rfd, r_res, r_addr, r_stb, r_we, r_sdat, r_padv);

            sel     = (r_addr[15:9] == 7'h2) && r_stb;
            spr_we  = sel && r_we;
            spr_re  = sel && !r_we && !r_padv;
            e_wren  = r_wb || spr_we;
            e_adr   = r_wb ? 8'(r_rfd) : 8'(r_addr[4:0]);
            e_dat   = r_wb ? r_res : r_sdat;
            e_ack   = (spr_we && !r_wb) || (spr_re && (m_prev_re != 0));
            e_stall = spr_we && (m_blocked >= LIMIT);

            @(negedge clk);
            chk($sformatf("rnd%0d", n), obs0(), pack(0, e_wren, e_ack, e_stall, e_adr, e_dat));
            chk($sformatf("rnd%0d_rdadr", n), 64'(bus0.spr_gpr_rdadr_o), 64'(r_addr[4:0]));

            m_prev_re = spr_re ? 1 : 0;
            if (spr_we && r_wb) m_blocked = (m_blocked < LIMIT) ? m_blocked + 1 : LIMIT;
            else                m_blocked = 0;
            next_cycle();
        end

        // writeback to r3 lands in context 0 on both RF sizes
        drive(1, 5'd3, 32'h33, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("wb_r3_5b", obs0(), pack(0, 1, 0, 0, 8'd3, 32'h33));
        chk("wb_r3_6b", obs1(), pack(0, 1, 0, 0, 8'd3, 32'h33));
        chk("rdadr_6b", 64'(bus1.spr_gpr_rdadr_o), 64'd0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // reset in the middle of the clear
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c <= 11; c++) begin
            @(negedge clk);
            if (c == 11) chk("midclr_adr10", obs0(), pack(1, 1, 0, 0, 8'd10, 0));
            next_cycle();
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midclr_rst0", obs0(), pack(1, 0, 0, 0, 0, 0));
        chk("midclr_rst1", obs1(), pack(1, 0, 0, 0, 0, 0));
        next_cycle();
        rst = 1'b0;
        clear_seq();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
